switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
- Input-conditioning stage directly upstream of the two-input (a, b) sequence-detector FSM on the DE2 board.
- Synchronizes raw slide-switch/pushbutton levels into the system clock domain and debounces each channel.
- Emits clean levels plus single-cycle rise/fall/changed strobes; the downstream FSM uses `changed` as its step enable instead of a switch-driven clock.

Parameters:
- WIDTH, 2, number of independent input channels (bit 1 = a, bit 0 = b for the detector).
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronized level must hold before it is accepted (10 ms at 50 MHz); legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived width of each channel's stability counter; not to be overridden.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-low reset.
- raw  input  WIDTH  unsynchronized switch levels.
- clean  output  WIDTH  debounced, synchronized levels.
- rise  output  WIDTH  1-cycle pulse per channel when clean goes 0->1.
- fall  output  WIDTH  1-cycle pulse per channel when clean goes 1->0.
- changed  output  1  OR of all rise and fall bits; 1-cycle step strobe for downstream.

Behaviour:
- Reset (reset=0, asynchronous, any time): clears sync stage 1, sync stage 2, all counters, clean, rise, fall and changed to 0. Outputs hold 0 while reset is low. Release is synchronous to the next clk edge.
- Synchronizer: two flops per channel, s1 <= raw and s2 <= s1. Only s2 is used downstream. No reset-free flops.
- Per-channel stability counter, evaluated every posedge:
  - If s2[i] == clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: clean[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- The counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Latency: if raw[i] is stable from before edge E, s2 reflects it after edge E+1, and clean updates at edge E+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=1, clean updates at edge E+2.
- Glitch rejection: any s2 return to the clean value before acceptance zeroes the counter, so no clean change occurs. A mismatch interval shorter than DEBOUNCE_CYCLES cycles is fully suppressed.
- Strobes:
  - rise, fall and changed are registered in the same edge that updates clean.
  - They are high for exactly one cycle, and deassert on the next edge unless a new acceptance occurs on that edge.
  - rise and fall for the same channel are never high together.
- Channels are fully independent. Simultaneous acceptance on several channels asserts several rise/fall bits in the same cycle, with a single changed pulse.
- Post-reset: if raw is held 1 through reset release, clean rises DEBOUNCE_CYCLES+2 edges after release with a rise pulse. This is required, not suppressed.
- Reset asserted mid-count: counters are discarded and the debounce restarts from 0 after release.
- No combinational path from raw to any output.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=2):
- Reset low for 3 cycles, raw=2'b00, then release -> clean=00, rise=fall=00, changed=0 throughout and for 20 cycles after.
- raw[1] 0->1 before edge E, held -> clean[1]=1 after edge E+5, rise=2'b10 and changed=1 for exactly that one cycle, then 0.
- raw[0] toggled 1 for 3 cycles, then 0 -> clean stays 00, no rise/fall/changed pulses.
- raw 00->11 in the same cycle -> clean=11 after edge E+5, rise=11 in one cycle, a single changed pulse; then raw 11->00 -> fall=11 after 5 edges.
- raw[1]=1 held, reset pulsed low for 1 cycle 3 edges after the raw change (mid-count) -> outputs 0 immediately; clean[1]=1 exactly 6 edges after release, with a rise pulse.
- Sequence a,b = 01, 11, 10, 00, each held 20 cycles -> changed pulses exactly 4 times (including the initial 00->01 acceptance), and clean tracks each value 5 edges after its change.

Source files
------------

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - two-flop synchronizer and per-channel debouncer with edge strobes
module switch_conditioner #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic             changed_nxt;

    // A channel's counter only runs while its synchronized level disagrees with
    // the accepted level; any agreement restarts the debounce window from zero.
    always_comb begin
        clean_nxt = clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != clean[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    clean_nxt[i] = s2[i];
                    rise_nxt[i]  = s2[i];
                    fall_nxt[i]  = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        changed_nxt = |(rise_nxt | fall_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= '0;
            s2      <= '0;
            clean   <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            clean   <= clean_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            changed <= changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - randomized and directed bench for switch_conditioner
module tb_switch_conditioner;
    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] raw = '0;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int total = 0;
    int bad = 0;
    int chg_cnt = 0;

    // Reference: raw delayed two edges, clean flips once the last D delayed samples all differ from it.
    logic [W-1:0] m_q0, m_q1, m_clean, m_rise, m_fall;
    logic         m_changed;
    logic [W-1:0] hist[$];

    always #5 clk = ~clk;

    switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .raw(raw),
        .clean(clean), .rise(rise), .fall(fall), .changed(changed)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q0 = '0; m_q1 = '0; m_clean = '0;
        m_rise = '0; m_fall = '0; m_changed = 1'b0;
        hist.delete();
        repeat (D) hist.push_back('0);
    endtask

    task automatic model_edge(input logic [W-1:0] r);
        logic [W-1:0] s2;
        bit all_diff;
        s2 = m_q1;
        m_q1 = m_q0;
        m_q0 = r;
        void'(hist.pop_front());
        hist.push_back(s2);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (hist[k]) if (hist[k][i] == m_clean[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_clean[i] = ~m_clean[i];
                if (m_clean[i]) m_rise[i] = 1'b1;
                else            m_fall[i] = 1'b1;
            end
        end
        m_changed = |(m_rise | m_fall);
    endtask

    task automatic step(input logic [W-1:0] r, input logic rs);
        @(negedge clk);
        raw = r;
        reset = rs;
        if (!rs) begin
            model_reset();
            #1;
            check("async_clean", int'(clean), 0);
            check("async_strobe", int'({rise, fall, changed}), 0);
        end
        @(posedge clk);
        if (rs) model_edge(r);
        else    model_reset();
        #1;
        check("clean", int'(clean), int'(m_clean));
        check("rise", int'(rise), int'(m_rise));
        check("fall", int'(fall), int'(m_fall));
        check("changed", int'(changed), int'(m_changed));
        if (changed) chg_cnt++;
    endtask

    task automatic hold_measure(input logic [W-1:0] r, input int n, input logic [W-1:0] target,
                                output int first);
        first = 0;
        for (int k = 1; k <= n; k++) begin
            step(r, 1'b1);
            if (first == 0 && clean == target) first = k;
        end
    endtask

    initial begin
        int first;
        int rise_hits;
        logic [W-1:0] seq [4];
        model_reset();

        // reset held with idle inputs, then quiet
        repeat (3) step(2'b00, 1'b0);
        chg_cnt = 0;
        repeat (20) step(2'b00, 1'b1);
        check("idle_pulses", chg_cnt, 0);

        // single channel rise latency
        chg_cnt = 0;
        hold_measure(2'b10, 20, 2'b10, first);
        check("lat_rise_a", first, D + 2);
        check("rise_a_pulses", chg_cnt, 1);
        repeat (20) step(2'b00, 1'b1);

        // glitch shorter than the window is suppressed
        chg_cnt = 0;
        repeat (D - 1) step(2'b01, 1'b1);
        repeat (12) step(2'b00, 1'b1);
        check("glitch_pulses", chg_cnt, 0);
        check("glitch_clean", int'(clean), 0);

        // simultaneous acceptance on both channels
        chg_cnt = 0;
        rise_hits = 0;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(2'b11, 1'b1);
            if (rise == 2'b11) rise_hits++;
            if (first == 0 && clean == 2'b11) first = k;
        end
        check("both_lat", first, D + 2);
        check("both_rise_hits", rise_hits, 1);
        check("both_changed", chg_cnt, 1);
        hold_measure(2'b00, 12, 2'b00, first);
        check("both_fall_lat", first, D + 2);

        // reset in the middle of a debounce count
        repeat (3) step(2'b10, 1'b1);
        step(2'b10, 1'b0);
        hold_measure(2'b10, 15, 2'b10, first);
        check("midrst_lat", first, D + 2);
        repeat (15) step(2'b00, 1'b1);

        // input held high through reset release
        repeat (2) step(2'b11, 1'b0);
        hold_measure(2'b11, 15, 2'b11, first);
        check("postrst_lat", first, D + 2);
        repeat (15) step(2'b00, 1'b1);

        // detector input sequence a,b = 01, 11, 10, 00
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        chg_cnt = 0;
        for (int s = 0; s < 4; s++) begin
            hold_measure(seq[s], 20, seq[s], first);
            check("seq_lat", first, D + 2);
        end
        check("seq_pulses", chg_cnt, 4);

        // randomized holds, some shorter than the window, with occasional resets
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] r;
            int len;
            r = W'($urandom_range(0, 3));
            len = $urandom_range(1, 2 * D);
            if ($urandom_range(0, 19) == 0) step(r, 1'b0);
            repeat (len) step(r, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
